// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution scheduler.
package conv_pkg;
  localparam int TAPS   = 9;
  localparam int PIX_W  = 4;
  localparam int SAMP_W = TAPS * PIX_W;
  localparam int RES_W  = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DRAIN    = 3'd2,
    CONV     = 3'd3,
    WAIT_RES = 3'd4,
    OUTPUT   = 3'd5,
    DONE     = 3'd6
  } state_e;
endpackage

// File: rtl/conv_addr_gen.sv
// Window position (row/col) and tap counters plus the frame RAM address for the current tap.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr_i,
  input  logic              tap_inc_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [3:0]        tap_o,
  output logic              last_tap_o,
  output logic              last_pos_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [3:0]    tap_q, tap_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_col, last_row;
  logic [1:0]    tap_r, tap_c;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tap_q <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      tap_q <= tap_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  always_comb begin
    last_col   = (col_q == CW'(IMG_W - 3));
    last_row   = (row_q == RW'(IMG_H - 3));
    last_tap_o = (tap_q == 4'(TAPS - 1));
    last_pos_o = last_col && last_row;
    tap_o      = tap_q;
  end

  // Advancing past the final position holds the counters; the next start clears them.
  always_comb begin
    tap_d = tap_q;
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      tap_d = '0;
      col_d = '0;
      row_d = '0;
    end else begin
      if (tap_inc_i) tap_d = last_tap_o ? 4'd0 : 4'(tap_q + 4'd1);
      if (advance_i) begin
        if (!last_col) begin
          col_d = CW'(col_q + CW'(1));
        end else if (!last_row) begin
          col_d = '0;
          row_d = RW'(row_q + RW'(1));
        end
      end
    end
  end

  always_comb begin
    tap_r  = 2'(tap_q / 4'd3);
    tap_c  = 2'(tap_q % 4'd3);
    addr_o = ADDR_W'((ADDR_W'(row_q) + ADDR_W'(tap_r)) * ADDR_W'(IMG_W))
           + ADDR_W'(col_q) + ADDR_W'(tap_c);
  end
endmodule

// File: rtl/conv_scheduler.sv
// Walks 3x3 windows over the frame RAM, feeds mult_add one window at a time
// and streams each result out over valid/ready.
//
//  state    | meaning
//  IDLE     | accept coefficient loads, wait for start
//  FETCH    | 9 RAM reads, one per tap
//  DRAIN    | capture read data for the last tap
//  CONV     | pulse conv_en to mult_add
//  WAIT_RES | wait for result_ready, latch result
//  OUTPUT   | present result until accepted, then next window or finish
//  DONE     | one-cycle done pulse
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              coeff_wr,
  input  logic [SAMP_W-1:0] coeff_load,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [SAMP_W-1:0] sample_out,
  output logic [SAMP_W-1:0] coeff_out,
  output logic              conv_en,
  input  logic [RES_W-1:0]  result_in,
  input  logic              result_ready,
  output logic [RES_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  state_e            state_q, state_d;
  logic [SAMP_W-1:0] sample_q, coeff_q;
  logic [RES_W-1:0]  out_data_q;
  logic              cap_en_q;
  logic [3:0]        cap_tap_q;

  logic [ADDR_W-1:0] gen_addr;
  logic [3:0]        gen_tap;
  logic              last_tap, last_pos;
  logic              clr, tap_inc, advance;

  conv_addr_gen #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_addr_gen (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr_i     (clr),
    .tap_inc_i (tap_inc),
    .advance_i (advance),
    .addr_o    (gen_addr),
    .tap_o     (gen_tap),
    .last_tap_o(last_tap),
    .last_pos_o(last_pos)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = FETCH;
      FETCH:    if (last_tap) state_d = DRAIN;
      DRAIN:    state_d = CONV;
      CONV:     state_d = WAIT_RES;
      WAIT_RES: if (result_ready) state_d = OUTPUT;
      OUTPUT:   if (out_ready) state_d = last_pos ? DONE : FETCH;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == FETCH);
    mem_addr  = (state_q == FETCH) ? gen_addr : '0;
    conv_en   = (state_q == CONV);
    out_valid = (state_q == OUTPUT);
    done      = (state_q == DONE);
    busy      = (state_q != IDLE) && (state_q != DONE);
    clr       = (state_q == IDLE) && start;
    tap_inc   = (state_q == FETCH);
    advance   = (state_q == OUTPUT) && out_ready;
  end

  // RAM data arrives one cycle after the read, so the tap index travels with it.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sample_q   <= '0;
      coeff_q    <= '0;
      out_data_q <= '0;
      cap_en_q   <= 1'b0;
      cap_tap_q  <= '0;
    end else begin
      cap_en_q  <= (state_q == FETCH);
      cap_tap_q <= gen_tap;
      if (cap_en_q) sample_q[32'(cap_tap_q) * PIX_W +: PIX_W] <= mem_rdata;
      if ((state_q == IDLE) && coeff_wr) coeff_q <= coeff_load;
      if ((state_q == WAIT_RES) && result_ready) out_data_q <= result_in;
    end
  end

  assign sample_out = sample_q;
  assign coeff_out  = coeff_q;
  assign out_data   = out_data_q;
endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler on a 4x4 frame with a RAM model and a latency-configurable mult_add model.
module tb_conv_scheduler;
  localparam int W = 4;
  localparam int H = 4;
  localparam int AW = $clog2(W * H);

  logic        clk = 1'b0;
  logic        n_rst, start, coeff_wr, out_ready;
  logic [35:0] coeff_load;
  logic        mem_rd_en, conv_en, out_valid, busy, done, result_ready;
  logic [AW-1:0] mem_addr;
  logic [3:0]  mem_rdata;
  logic [35:0] sample_out, coeff_out;
  logic [15:0] result_in, out_data;

  conv_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .coeff_wr(coeff_wr), .coeff_load(coeff_load),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .sample_out(sample_out), .coeff_out(coeff_out), .conv_en(conv_en),
    .result_in(result_in), .result_ready(result_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [3:0] mem [W*H];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  function automatic logic [15:0] mac(input logic [35:0] s, input logic [35:0] c);
    int acc = 0;
    for (int k = 0; k < 9; k++) acc += int'(s[4*k +: 4]) * int'(c[4*k +: 4]);
    return 16'(acc);
  endfunction

  int lat = 1;
  int ma_cnt;
  bit ma_pend;
  logic [15:0] ma_hold;
  always @(posedge clk) begin
    if (!n_rst) begin
      result_ready <= 1'b0; result_in <= '0; ma_pend <= 1'b0; ma_cnt <= 0;
    end else begin
      result_ready <= 1'b0;
      if (conv_en) begin
        if (lat <= 1) begin
          result_ready <= 1'b1; result_in <= mac(sample_out, coeff_out);
        end else begin
          ma_pend <= 1'b1; ma_cnt <= lat - 1; ma_hold <= mac(sample_out, coeff_out);
        end
      end else if (ma_pend) begin
        if (ma_cnt == 1) begin
          result_ready <= 1'b1; result_in <= ma_hold; ma_pend <= 1'b0;
        end else ma_cnt <= ma_cnt - 1;
      end
    end
  end

  logic [15:0] got[$];
  logic [15:0] exp_q[$];
  int addrs[$];
  int done_cnt, conv_cnt, busy_at_done;
  always @(negedge clk) begin
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) done_cnt++;
    if (done && busy) busy_at_done++;
    if (conv_en) conv_cnt++;
    if (mem_rd_en) addrs.push_back(int'(mem_addr));
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_rd_en"}, mem_rd_en, 0);
    chk({pfx, "_addr"}, mem_addr, 0);
    chk({pfx, "_sample"}, sample_out, 0);
    chk({pfx, "_coeff"}, coeff_out, 0);
    chk({pfx, "_conv_en"}, conv_en, 0);
    chk({pfx, "_out_data"}, out_data, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
  endtask

  // Reference: each window is the plain dot product of RAM pixels and coefficients, raster order.
  function automatic void ref_frame(input logic [35:0] cf);
    exp_q.delete();
    for (int y = 0; y <= H - 3; y++)
      for (int x = 0; x <= W - 3; x++) begin
        int acc = 0;
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            acc += int'(mem[(y + dy) * W + x + dx]) * int'(cf[4 * (dy * 3 + dx) +: 4]);
        exp_q.push_back(16'(acc));
      end
  endfunction

  task automatic fill_mem(input int mode);
    for (int a = 0; a < W * H; a++)
      mem[a] = (mode == 0) ? 4'(a) : (mode == 1) ? 4'hF : 4'($urandom_range(0, 15));
  endtask

  task automatic kick(input logic [35:0] cf);
    got.delete(); addrs.delete();
    done_cnt = 0; conv_cnt = 0; busy_at_done = 0;
    coeff_wr = 1'b1; coeff_load = cf; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; coeff_wr = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("coeff_loaded", coeff_out, cf);
  endtask

  task automatic wait_done(input bit rnd);
    int c = 0;
    while (done_cnt == 0 && c < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    chk("frame_finished", done_cnt != 0, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("single_done", done_cnt, 1);
    chk("busy_low_in_done", busy_at_done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic cmp_results(input string nm);
    chk({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_res%0d", nm, i), got[i], exp_q[i]);
  endtask

  typedef struct {
    logic [35:0] coeff;
    int          pix_mode;
    int          lat;
    logic [15:0] e0, e1, e2, e3;
  } vec_t;
  vec_t vecs [6];

  initial begin
    vecs[0] = '{36'h111111111, 0, 1, 16'd45, 16'd54, 16'd81, 16'd90};
    vecs[1] = '{36'h000000001, 0, 1, 16'd0,  16'd1,  16'd4,  16'd5};
    vecs[2] = '{36'h100000000, 0, 2, 16'd10, 16'd11, 16'd14, 16'd15};
    vecs[3] = '{36'hfffffffff, 1, 1, 16'h07E9, 16'h07E9, 16'h07E9, 16'h07E9};
    vecs[4] = '{36'h111111111, 0, 3, 16'd45, 16'd54, 16'd81, 16'd90};
    vecs[5] = '{36'h000000012, 0, 1, 16'd1,  16'd4,  16'd13, 16'd16};

    n_rst = 1'b0; start = 1'b0; coeff_wr = 1'b0; coeff_load = '0; out_ready = 1'b1;
    fill_mem(0);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      fill_mem(vecs[i].pix_mode);
      lat = vecs[i].lat;
      kick(vecs[i].coeff);
      wait_done(1'b0);
      exp_q.delete();
      exp_q.push_back(vecs[i].e0); exp_q.push_back(vecs[i].e1);
      exp_q.push_back(vecs[i].e2); exp_q.push_back(vecs[i].e3);
      cmp_results($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_conv_pulses", i), conv_cnt, 4);
      chk($sformatf("vec%0d_reads", i), addrs.size(), 36);
      if (addrs.size() == 36) begin
        int wa[9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        for (int k = 0; k < 9; k++)
          chk($sformatf("vec%0d_addr11_tap%0d", i, k), addrs[27 + k], wa[k]);
      end
    end

    // Output stall on the first result.
    fill_mem(0); lat = 1;
    out_ready = 1'b0;
    kick(36'h111111111);
    begin
      int c = 0;
      int n_rd, n_cv;
      while (!out_valid && c < 200) begin @(negedge clk); c++; end
      chk("stall_reached", out_valid, 1);
      n_rd = addrs.size(); n_cv = conv_cnt;
      for (int i = 0; i < 5; i++) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, 45);
        chk("stall_no_rd", mem_rd_en, 0);
        @(negedge clk);
      end
      chk("stall_reads_frozen", addrs.size(), n_rd);
      chk("stall_conv_frozen", conv_cnt, n_cv);
    end
    @(posedge clk); #1;
    wait_done(1'b0);
    ref_frame(36'h111111111);
    cmp_results("stall");

    // start/coeff_wr while busy must be ignored.
    kick(36'h111111111);
    @(posedge clk); #1;
    chk("ign_in_fetch", mem_rd_en, 1);
    start = 1'b1; coeff_wr = 1'b1; coeff_load = 36'h222222222;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0; coeff_wr = 1'b0;
    wait_done(1'b0);
    cmp_results("ignored");
    chk("ign_coeff_kept", coeff_out, 36'h111111111);

    // Reset in the middle of window 2's fetch.
    kick(36'h111111111);
    begin
      int c = 0;
      while (!(got.size() == 1 && mem_rd_en) && c < 200) begin @(posedge clk); #1; c++; end
      chk("rst_reached_win2", got.size() == 1 && mem_rd_en, 1);
    end
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    chk_zero("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_stays_idle", busy, 0);
    kick(36'h111111111);
    wait_done(1'b0);
    cmp_results("after_rst");

    // Randomized frames against the reference model.
    for (int r = 0; r < 5; r++) begin
      logic [35:0] cf;
      fill_mem(2);
      cf = {4'($urandom_range(0, 15)), 32'($urandom)};
      lat = int'($urandom_range(1, 4));
      ref_frame(cf);
      kick(cf);
      wait_done(1'b1);
      cmp_results($sformatf("rand%0d", r));
      chk($sformatf("rand%0d_conv_pulses", r), conv_cnt, 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
